// File: rtl/axis_trigger_framer.sv
// Gates a continuous AXI4-Stream sample stream into triggered, fixed-length tlast frames.
// Optional level-crossing trigger is enabled by defining THRESHOLD_TRIG_EN.
module axis_trigger_framer #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned LEN_WIDTH     = 16,
    parameter int unsigned HOLDOFF_WIDTH = 16,
    parameter int unsigned MAX_LENGTH    = 1000
) (
    input  logic                     clk,
    input  logic                     resetn,
    output logic                     s_tready,
    input  logic                     s_tvalid,
    input  logic [DATA_WIDTH-1:0]    s_tdata,
    input  logic                     trig_in,
    input  logic                     m_tready,
    output logic                     m_tvalid,
    output logic [DATA_WIDTH-1:0]    m_tdata,
    output logic                     m_tlast,
    input  logic                     cfg_enable,
    input  logic [LEN_WIDTH-1:0]     cfg_length,
    input  logic [HOLDOFF_WIDTH-1:0] cfg_holdoff,
    input  logic [DATA_WIDTH-1:0]    cfg_threshold,
    output logic                     busy,
    output logic [31:0]              frame_count,
    output logic                     cfg_err,
    output logic                     drop_err
);

    localparam logic [LEN_WIDTH-1:0]     MaxLen  = LEN_WIDTH'(MAX_LENGTH);
    localparam logic [LEN_WIDTH-1:0]     LenOne  = LEN_WIDTH'(1);
    localparam logic [HOLDOFF_WIDTH-1:0] HoldOne = HOLDOFF_WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StArmed, StCapture, StHoldoff} state_e;

    state_e                   state_q, state_d;
    logic [LEN_WIDTH-1:0]     beat_q, beat_d;
    logic [LEN_WIDTH-1:0]     len_q, len_d;
    logic [HOLDOFF_WIDTH-1:0] hold_q, hold_d;
    logic                     fwd, fwd_last, cfg_err_set;
    logic                     trig, len_legal;

`ifdef THRESHOLD_TRIG_EN
    logic [DATA_WIDTH-1:0] prev_q;
    logic                  crossing;

    // Previous sample starts at the most negative value so the first sample at/above
    // threshold counts as a rising crossing.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_q <= {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else if (s_tvalid) begin
            prev_q <= s_tdata;
        end
    end

    assign crossing = ($signed(s_tdata) >= $signed(cfg_threshold)) &&
                      ($signed(prev_q) < $signed(cfg_threshold));
    assign trig     = trig_in | crossing;
`else
    logic unused_threshold;
    assign unused_threshold = ^cfg_threshold;
    assign trig             = trig_in;
`endif

    assign len_legal = (cfg_length != '0) && (cfg_length <= MaxLen);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            beat_q  <= '0;
            len_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        len_d       = len_q;
        hold_d      = hold_q;
        fwd         = 1'b0;
        fwd_last    = 1'b0;
        cfg_err_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cfg_enable) state_d = StArmed;
            end
            StArmed: begin
                if (!cfg_enable) begin
                    state_d = StIdle;
                end else if (s_tvalid && trig) begin
                    if (len_legal) begin
                        len_d = cfg_length;
                        fwd   = 1'b1;
                        if (cfg_length == LenOne) begin
                            fwd_last = 1'b1;
                            hold_d   = cfg_holdoff;
                            beat_d   = '0;
                            state_d  = StHoldoff;
                        end else begin
                            beat_d  = LenOne;
                            state_d = StCapture;
                        end
                    end else begin
                        cfg_err_set = 1'b1;
                    end
                end
            end
            StCapture: begin
                if (s_tvalid) begin
                    fwd = 1'b1;
                    if (beat_q == len_q - LenOne) begin
                        fwd_last = 1'b1;
                        hold_d   = cfg_holdoff;
                        beat_d   = '0;
                        state_d  = StHoldoff;
                    end else begin
                        beat_d = beat_q + LenOne;
                    end
                end
            end
            StHoldoff: begin
                // The beat that drains the last holdoff count leaves in the same cycle.
                if ((hold_q == '0) || (s_tvalid && (hold_q == HoldOne))) begin
                    hold_d  = '0;
                    state_d = cfg_enable ? StArmed : StIdle;
                end else if (s_tvalid) begin
                    hold_d = hold_q - HoldOne;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        s_tready = 1'b1;
        busy     = (state_q == StCapture) || (state_q == StHoldoff);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_tvalid    <= 1'b0;
            m_tdata     <= '0;
            m_tlast     <= 1'b0;
            frame_count <= '0;
            cfg_err     <= 1'b0;
            drop_err    <= 1'b0;
        end else begin
            if (cfg_err_set) cfg_err <= 1'b1;
            if (fwd) begin
                m_tvalid <= 1'b1;
                m_tdata  <= s_tdata;
                m_tlast  <= fwd_last;
                if (m_tvalid && !m_tready) drop_err <= 1'b1;
                if (fwd_last) frame_count <= frame_count + 32'd1;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_trigger_framer.sv
// Directed self-checking bench for axis_trigger_framer; the threshold case runs only
// when THRESHOLD_TRIG_EN is defined.
module tb_axis_trigger_framer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        s_tready;
    logic        s_tvalid = 1'b0;
    logic [15:0] s_tdata = '0;
    logic        trig_in = 1'b0;
    logic        m_tready = 1'b1;
    logic        m_tvalid;
    logic [15:0] m_tdata;
    logic        m_tlast;
    logic        cfg_enable = 1'b0;
    logic [15:0] cfg_length = '0;
    logic [15:0] cfg_holdoff = '0;
    logic [15:0] cfg_threshold = 16'h7fff;
    logic        busy;
    logic [31:0] frame_count;
    logic        cfg_err;
    logic        drop_err;

    int checks = 0;
    int errors = 0;

    axis_trigger_framer dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_tready      (s_tready),
        .s_tvalid      (s_tvalid),
        .s_tdata       (s_tdata),
        .trig_in       (trig_in),
        .m_tready      (m_tready),
        .m_tvalid      (m_tvalid),
        .m_tdata       (m_tdata),
        .m_tlast       (m_tlast),
        .cfg_enable    (cfg_enable),
        .cfg_length    (cfg_length),
        .cfg_holdoff   (cfg_holdoff),
        .cfg_threshold (cfg_threshold),
        .busy          (busy),
        .frame_count   (frame_count),
        .cfg_err       (cfg_err),
        .drop_err      (drop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        trig_in  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d, input logic t);
        s_tvalid = 1'b1;
        s_tdata  = d;
        trig_in  = t;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        trig_in  = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
    endtask

    // Check one output beat: valid flag, and data/last when a beat is expected.
    task automatic expect_out(input string tag, input logic v, input int d, input logic l);
        check({tag, "_valid"}, 32'(m_tvalid), 32'(v));
        if (v) begin
            check({tag, "_data"}, 32'(m_tdata), 32'(d));
            check({tag, "_last"}, 32'(m_tlast), 32'(l));
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", 32'(m_tvalid), 32'd0);
        check("rst_data", 32'(m_tdata), 32'd0);
        check("rst_last", 32'(m_tlast), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", frame_count, 32'd0);
        check("rst_cfgerr", 32'(cfg_err), 32'd0);
        check("rst_droperr", 32'(drop_err), 32'd0);
        check("tready", 32'(s_tready), 32'd1);

        // 1: single triggered frame
        cfg_enable = 1'b1; cfg_length = 16'd4; cfg_holdoff = 16'd2; m_tready = 1'b1;
        idle(1);
        for (int s = 0; s <= 8; s++) begin
            beat(16'(s), s == 5);
            expect_out("t1", s >= 5, s, s == 8);
        end
        beat(16'd9, 1'b0);
        check("t1_after_valid", 32'(m_tvalid), 32'd0);
        check("t1_busy_hold", 32'(busy), 32'd1);
        check("t1_count", frame_count, 32'd1);
        check("t1_droperr", 32'(drop_err), 32'd0);

        // 2: trigger held high, holdoff separates frames
        do_reset();
        idle(1);
        for (int s = 0; s <= 14; s++) begin
            beat(16'(s), s >= 5);
            expect_out("t2", ((s >= 5) && (s <= 8)) || ((s >= 11) && (s <= 14)), s,
                       (s == 8) || (s == 14));
        end
        check("t2_count", frame_count, 32'd2);
        check("t2_cfgerr", 32'(cfg_err), 32'd0);
        check("t2_droperr", 32'(drop_err), 32'd0);

        // 3: illegal length 0, then a legal 3-beat frame
        do_reset();
        cfg_length = 16'd0;
        idle(1);
        beat(16'd0, 1'b1);
        check("t3_cfgerr", 32'(cfg_err), 32'd1);
        check("t3_novalid", 32'(m_tvalid), 32'd0);
        cfg_length = 16'd3;
        for (int s = 1; s <= 5; s++) begin
            beat(16'(s), s == 2);
            expect_out("t3", (s >= 2) && (s <= 4), s, s == 4);
        end
        check("t3_cfgerr_sticky", 32'(cfg_err), 32'd1);
        check("t3_count", frame_count, 32'd1);

        // Length boundaries: MAX_LENGTH+1 rejected, MAX_LENGTH accepted
        do_reset();
        cfg_length = 16'd1001;
        idle(1);
        beat(16'd7, 1'b1);
        check("len1001_cfgerr", 32'(cfg_err), 32'd1);
        check("len1001_valid", 32'(m_tvalid), 32'd0);
        do_reset();
        cfg_length = 16'd1000;
        idle(1);
        beat(16'd7, 1'b1);
        check("len1000_cfgerr", 32'(cfg_err), 32'd0);
        check("len1000_valid", 32'(m_tvalid), 32'd1);
        check("len1000_busy", 32'(busy), 32'd1);

        // 4: downstream stalled during a frame
        do_reset();
        cfg_length = 16'd4; cfg_holdoff = 16'd2; m_tready = 1'b0;
        idle(1);
        for (int s = 0; s <= 5; s++) beat(16'(s), s == 5);
        check("t4_drop_first", 32'(drop_err), 32'd0);
        beat(16'd6, 1'b0);
        check("t4_drop_set", 32'(drop_err), 32'd1);
        beat(16'd7, 1'b0);
        beat(16'd8, 1'b0);
        expect_out("t4_end", 1'b1, 8, 1'b1);
        check("t4_count", frame_count, 32'd1);
        m_tready = 1'b1;
        idle(1);
        check("t4_drained", 32'(m_tvalid), 32'd0);

        // 5: reset mid-frame
        do_reset();
        cfg_length = 16'd4;
        idle(1);
        beat(16'd0, 1'b1);
        beat(16'd1, 1'b0);
        beat(16'd2, 1'b0);
        expect_out("t5_pre", 1'b1, 2, 1'b0);
        resetn = 1'b0;
        idle(1);
        check("t5_valid", 32'(m_tvalid), 32'd0);
        check("t5_data", 32'(m_tdata), 32'd0);
        check("t5_last", 32'(m_tlast), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_count", frame_count, 32'd0);
        resetn = 1'b1;
        cfg_enable = 1'b0;
        beat(16'd3, 1'b1);
        check("t5_idle_valid", 32'(m_tvalid), 32'd0);
        check("t5_idle_busy", 32'(busy), 32'd0);

        // Length 1 with holdoff 0: every other beat is a one-beat frame
        do_reset();
        cfg_enable = 1'b1; cfg_length = 16'd1; cfg_holdoff = 16'd0;
        idle(1);
        for (int s = 0; s <= 4; s++) begin
            beat(16'(s + 20), 1'b1);
            expect_out("len1", (s % 2) == 0, s + 20, 1'b1);
        end
        check("len1_count", frame_count, 32'd3);

        // Disabling mid-frame finishes the frame, then stays idle
        do_reset();
        cfg_length = 16'd2; cfg_holdoff = 16'd0;
        idle(1);
        beat(16'd30, 1'b1);
        cfg_enable = 1'b0;
        beat(16'd31, 1'b1);
        expect_out("dis_last", 1'b1, 31, 1'b1);
        beat(16'd32, 1'b1);
        beat(16'd33, 1'b1);
        check("dis_valid", 32'(m_tvalid), 32'd0);
        check("dis_busy", 32'(busy), 32'd0);
        check("dis_count", frame_count, 32'd1);

`ifdef THRESHOLD_TRIG_EN
        // 6: rising threshold crossing
        do_reset();
        cfg_enable = 1'b1; cfg_length = 16'd1; cfg_holdoff = 16'd0; cfg_threshold = 16'd100;
        idle(1);
        begin
            logic [15:0] samp [6];
            samp = '{16'd50, 16'd99, 16'd100, 16'd150, 16'd150, 16'd150};
            for (int i = 0; i < 6; i++) begin
                beat(samp[i], 1'b0);
                expect_out("thr", i == 2, 100, 1'b1);
            end
        end
        check("thr_count", frame_count, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
